// File: rtl/b03_req_pkg.sv
// Shared types and helpers for the b03 requester subsystem.
package b03_req_pkg;

  localparam int unsigned N_CLIENTS = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    USE,
    REL
  } req_state_t;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [N_CLIENTS-1:0] v);
    return (v & (v - N_CLIENTS'(1))) == '0;
  endfunction

endpackage

// File: rtl/b03_req_agent.sv
// One requester agent: accepts a job, requests the resource, holds it for the
// programmed number of granted cycles, then releases and waits for the grant to drop.
module b03_req_agent
  import b03_req_pkg::*;
#(
  parameter int unsigned HOLD_W  = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [HOLD_W-1:0] job_hold,
  input  logic              grant,
  output logic              request,
  output logic              done,
  output logic              timeout_err,
  output logic              early_revoke,
  output req_state_t        state
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] use_cnt;

  assign job_ready    = (state == IDLE);
  assign early_revoke = (state == USE) && !grant && (use_cnt > HOLD_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      request     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
      use_cnt     <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            // A zero hold still occupies the resource for one granted cycle.
            hold_cnt <= (job_hold == '0) ? HOLD_W'(1) : job_hold;
            wait_cnt <= '0;
            request  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (grant) begin
            use_cnt <= hold_cnt;
            state   <= USE;
          end else if (wait_cnt == WaitLast) begin
            request     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        USE: begin
          if (grant && use_cnt > HOLD_W'(1)) begin
            use_cnt <= use_cnt - HOLD_W'(1);
          end else begin
            // Last granted cycle, or the arbiter revoked the grant.
            request <= 1'b0;
            state   <= REL;
          end
        end
        REL: begin
          if (!grant) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/b03_requester.sv
// Four independent requester agents plus arbiter-side protocol checking
// folded into a sticky proto_err flag.
module b03_requester
  import b03_req_pkg::*;
#(
  parameter int unsigned HOLD_W  = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CLIENTS-1:0]        job_valid,
  output logic [N_CLIENTS-1:0]        job_ready,
  input  logic [N_CLIENTS*HOLD_W-1:0] job_hold,
  output logic [N_CLIENTS-1:0]        request,
  input  logic [N_CLIENTS-1:0]        grant_o,
  output logic [N_CLIENTS-1:0]        done,
  output logic [N_CLIENTS-1:0]        timeout_err,
  output logic                        proto_err
);

  req_state_t           state [N_CLIENTS];
  logic [N_CLIENTS-1:0] early_revoke;
  logic [N_CLIENTS-1:0] agent_err;
  logic [N_CLIENTS-1:0] grant_q;
  logic                 proto_hit;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_agent
    b03_req_agent #(
      .HOLD_W (HOLD_W),
      .TIMEOUT(TIMEOUT)
    ) u_agent (
      .clock       (clock),
      .reset       (reset),
      .job_valid   (job_valid[i]),
      .job_ready   (job_ready[i]),
      .job_hold    (job_hold[i*HOLD_W +: HOLD_W]),
      .grant       (grant_o[i]),
      .request     (request[i]),
      .done        (done[i]),
      .timeout_err (timeout_err[i]),
      .early_revoke(early_revoke[i]),
      .state       (state[i])
    );
  end

  always_comb begin
    agent_err = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      agent_err[i] = early_revoke[i]
                   || (grant_o[i] && (state[i] == IDLE))
                   || (grant_o[i] && !grant_q[i] && (state[i] == REL));
    end
    proto_hit = !onehot0(grant_o) || (|agent_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      grant_q <= grant_o;
      if (proto_hit) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_b03_requester.sv
// Directed bench for b03_requester with a job-level reference model checked every cycle.
module tb_b03_requester;

  localparam int TIMEOUT = 32;
  localparam int PH_FREE = 0;
  localparam int PH_ASK  = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_REL  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  job_valid;
  logic [3:0]  job_ready;
  logic [15:0] job_hold;
  logic [3:0]  request;
  logic [3:0]  grant_o;
  logic [3:0]  done;
  logic [3:0]  timeout_err;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  b03_requester #(
    .HOLD_W (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_hold   (job_hold),
    .request    (request),
    .grant_o    (grant_o),
    .done       (done),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each client's job is tracked by phase, start cycle and granted cycles.
  int         ph [4];
  int         t_ask [4];
  int         got [4];
  int         need [4];
  int         cyc = 0;
  logic [3:0] g_prev, m_done, m_to, m_req, m_ready;
  logic       m_proto, viol;

  // Per-test observations of the DUT for the literal checks.
  int reqcnt [4];
  int ovl [4];
  int dn [4];
  int to [4];
  int done_q[$];

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) ph[i] = PH_FREE;
      m_proto = 1'b0;
      m_done  = '0;
      m_to    = '0;
      g_prev  = '0;
    end else begin
      viol   = ((grant_o & (grant_o - 4'd1)) != 4'd0);
      m_done = '0;
      m_to   = '0;
      for (int i = 0; i < 4; i++) begin
        case (ph[i])
          PH_FREE: begin
            if (grant_o[i]) viol = 1'b1;
            if (job_valid[i]) begin
              ph[i]    = PH_ASK;
              t_ask[i] = cyc;
              got[i]   = 0;
              need[i]  = (job_hold[i*4 +: 4] == 4'd0) ? 1 : int'(job_hold[i*4 +: 4]);
            end
          end
          PH_ASK: begin
            if (grant_o[i]) ph[i] = PH_HOLD;
            else if (cyc - t_ask[i] >= TIMEOUT) begin
              ph[i]   = PH_FREE;
              m_to[i] = 1'b1;
            end
          end
          PH_HOLD: begin
            if (grant_o[i]) begin
              got[i]++;
              if (got[i] >= need[i]) ph[i] = PH_REL;
            end else begin
              if (need[i] - got[i] > 1) viol = 1'b1;
              ph[i] = PH_REL;
            end
          end
          default: begin
            if (grant_o[i] && !g_prev[i]) viol = 1'b1;
            if (!grant_o[i]) begin
              ph[i]     = PH_FREE;
              m_done[i] = 1'b1;
            end
          end
        endcase
      end
      if (viol) m_proto = 1'b1;
      g_prev = grant_o;
    end
    for (int i = 0; i < 4; i++) begin
      m_req[i]   = (ph[i] == PH_ASK) || (ph[i] == PH_HOLD);
      m_ready[i] = (ph[i] == PH_FREE);
    end
    #2;
    check("request", request, m_req);
    check("job_ready", job_ready, m_ready);
    check("done", done, m_done);
    check("timeout_err", timeout_err, m_to);
    check("proto_err", proto_err, m_proto);
    for (int i = 0; i < 4; i++) begin
      if (request[i]) reqcnt[i]++;
      if (request[i] && grant_o[i]) ovl[i]++;
      if (timeout_err[i]) to[i]++;
      if (done[i]) begin
        dn[i]++;
        done_q.push_back(i);
      end
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      reqcnt[i] = 0;
      ovl[i]    = 0;
      dn[i]     = 0;
      to[i]     = 0;
    end
    done_q.delete();
  endtask

  task automatic offer(input logic [3:0] mask, input logic [15:0] holds);
    job_valid = mask;
    job_hold  = holds;
    @(negedge clock);
    job_valid = '0;
  endtask

  task automatic wait_req(input int i, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (request[i] === lvl) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    check($sformatf("wait_req%0d", i), request[i], lvl);
  endtask

  // Grant client i two cycles after it requests; keep>0 revokes after keep cycles,
  // otherwise the grant is held until request falls.
  task automatic serve(input int i, input int keep);
    bit ok;
    wait_req(i, 1'b1, ok);
    if (!ok) return;
    repeat (2) @(negedge clock);
    grant_o = 4'(1) << i;
    if (keep > 0) repeat (keep) @(negedge clock);
    else wait_req(i, 1'b0, ok);
    grant_o = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset     = 1'b1;
    job_valid = '0;
    job_hold  = '0;
    grant_o   = '0;
    clear_stats();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #3;
    check("rst_ready", job_ready, 4'hF);
    check("rst_request", request, 4'h0);
    check("rst_proto", proto_err, 1'b0);
    @(negedge clock);

    // Single job, client0 hold=3.
    clear_stats();
    offer(4'b0001, 16'h0003);
    serve(0, -1);
    repeat (3) @(negedge clock);
    check("t1_overlap0", ovl[0], 3);
    check("t1_done0", dn[0], 1);
    check("t1_proto", proto_err, 1'b0);

    // Hold of zero behaves as one.
    clear_stats();
    offer(4'b0010, 16'h0000);
    serve(1, -1);
    repeat (3) @(negedge clock);
    check("t1b_overlap1", ovl[1], 1);
    check("t1b_done1", dn[1], 1);

    // Timeout on client2.
    clear_stats();
    offer(4'b0100, 16'h0500);
    repeat (40) @(negedge clock);
    check("t2_reqcycles2", reqcnt[2], 32);
    check("t2_timeout2", to[2], 1);
    check("t2_done2", dn[2], 0);
    check("t2_ready2", job_ready[2], 1'b1);

    // Contention: all four, hold=2, served in order.
    clear_stats();
    offer(4'b1111, 16'h2222);
    for (int i = 0; i < 4; i++) serve(i, -1);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_overlap%0d", i), ovl[i], 2);
      check($sformatf("t3_timeout%0d", i), to[i], 0);
    end
    check("t3_done_count", done_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < done_q.size()) check($sformatf("t3_done_order%0d", i), done_q[i], i);
    end
    check("t3_proto", proto_err, 1'b0);

    // Protocol violation: two grants at once.
    grant_o = 4'b0110;
    @(posedge clock); #3;
    check("t4_proto_set", proto_err, 1'b1);
    @(negedge clock);
    grant_o = '0;
    repeat (5) @(negedge clock);
    check("t4_proto_sticky", proto_err, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #3;
    check("t4_proto_cleared", proto_err, 1'b0);
    @(negedge clock);

    // Early revoke: client1 hold=8, grant removed after 3 cycles.
    clear_stats();
    offer(4'b0010, 16'h0080);
    serve(1, 3);
    @(posedge clock); #3;
    check("t5_proto", proto_err, 1'b1);
    check("t5_req1_low", request[1], 1'b0);
    @(negedge clock);
    repeat (2) @(negedge clock);
    check("t5_done1", dn[1], 1);
    check("t5_overlap1", ovl[1], 3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset while client3 holds the grant.
    clear_stats();
    offer(4'b1000, 16'hA000);
    wait_req(3, 1'b1, ok);
    repeat (2) @(negedge clock);
    grant_o = 4'b1000;
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    grant_o = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #3;
    check("t6_request", request, 4'h0);
    check("t6_ready", job_ready, 4'hF);
    @(negedge clock);
    repeat (4) @(negedge clock);
    check("t6_no_done", dn[3], 0);
    check("t6_proto", proto_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b03_requester.md
Name: b03_requester

Overview:
- Client-side counterpart of the b03 four-way resource arbiter. Holds four independent requester agents.
- Each agent accepts a job, drives its REQUEST line and waits for its GRANT_O bit. It holds the resource for a programmed number of cycles, then releases it and waits for the grant to drop.
- Also checks arbiter-side protocol (one-hot grant, grant only to a requester) for system-level benches and the integrated client subsystem.

Parameters:
- N_CLIENTS, 4, number of requester agents; fixed at 4 to match REQUEST1..4 and GRANT_O[3:0].
- HOLD_W, 4, width of the per-job hold-count field.
- TIMEOUT, 32, maximum cycles in REQ before the request is abandoned; must be >=2.

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- job_valid  in  4  per-client job offer; bit i belongs to client i
- job_ready  out  4  per-client job accept; high only in IDLE
- job_hold  in  4*HOLD_W  per-client hold cycles; slice i is [i*HOLD_W +: HOLD_W]
- request  out  4  REQUEST4..1 to the arbiter; bit0 is REQUEST1; registered
- grant_o  in  4  GRANT_O_REG[3:0] from the arbiter; bit i grants client i
- done  out  4  one-cycle pulse when a job completes normally
- timeout_err  out  4  one-cycle pulse when a request is abandoned
- proto_err  out  1  sticky flag for an arbiter protocol violation; cleared only by reset

Behaviour:
- Reset values (synchronous, wins over all other events including mid-job):
  - all agents go to IDLE;
  - request=0, done=0, timeout_err=0, proto_err=0;
  - job_ready=4'b1111 in the cycle after reset deasserts;
  - counters=0.
- Per-agent FSM states: IDLE, REQ, USE, REL. All outputs are registered or decoded from state.
- IDLE:
  - job_ready=1, request=0.
  - job_valid&job_ready captures hold into hold_cnt. A hold of 0 is treated as 1.
  - Next state REQ. request rises on the cycle after acceptance.
- REQ:
  - request=1 and wait_cnt increments each cycle.
  - If grant_o[i]=1: go to USE and load use_cnt=hold.
  - Else if wait_cnt==TIMEOUT-1: go to IDLE, pulse timeout_err[i] and drop request.
  - Grant and timeout in the same cycle: grant wins.
- USE:
  - request=1 and use_cnt decrements each cycle the grant is present.
  - When use_cnt==1 and grant present: go to REL.
  - If grant_o[i] drops while use_cnt>1: set proto_err and go to REL (early revoke).
- REL:
  - request=0 for at least 1 cycle.
  - Stay until grant_o[i]==0, then pulse done[i] and go to IDLE. job_ready returns on the same cycle done pulses.
  - If the arbiter never drops the grant, the agent stays in REL; there is no timeout here.
- Latency: job accept to request high is 1 cycle. Grant-sampled to request low is exactly hold cycles. done fires no earlier than 1 cycle after request falls.
- Global checks (combinational in, registered into sticky proto_err):
  - grant_o not one-hot-or-zero (e.g. 4'b0011);
  - grant_o[i]=1 while agent i is in IDLE;
  - grant_o[i] rising while agent i is in REL.
- Agents run fully independently. Multiple simultaneous job_valid are all accepted in the same cycle.
- Counters saturate and never wrap. wait_cnt width is clog2(TIMEOUT); use_cnt width is HOLD_W.

Decomposition:
- Package b03_req_pkg holds:
  - req_state_t enum {IDLE, REQ, USE, REL};
  - the N_CLIENTS constant;
  - a one-hot check function.
- Sub-module b03_req_agent: one FSM plus its wait and use counters, instantiated 4 times.
- Top level holds the job slicing, the global one-hot / proto_err logic and the output concatenation.

Test Plan:
- Single job: client0, hold=3; grant_o=0001 two cycles after request rises, dropped after request falls. Expect request[0] high exactly 3 grant cycles, then done[0] pulse, proto_err=0.
- Timeout: client2 job with grant never given. Expect request[2] high 32 cycles, timeout_err[2] pulse, back to IDLE with job_ready[2]=1.
- Contention: all four jobs, hold=2, arbiter model grants in order 1,2,3,4. Expect four done pulses in grant order and no overlapping request-while-granted beyond hold.
- Protocol violation: drive grant_o=0110 for one cycle. Expect proto_err=1 the next cycle, held until reset.
- Early revoke: client1 hold=8, grant dropped after 3 cycles. Expect proto_err=1, request[1] falls, then done[1] pulses.
- Reset mid-USE: assert reset while client3 holds the grant. Expect request=0 and job_ready=1111 one cycle after reset is released, with no done pulse.
